// File: rtl/video_ctrl_pkg.sv
// Shared opcodes, colour-mode codes, sequencer state type and opcode classification
// for the video control sequencer.
package video_ctrl_pkg;

   localparam logic [7:0] OP_NOP        = 8'd0;
   localparam logic [7:0] OP_COLORMODE  = 8'd1;
   localparam logic [7:0] OP_DIMENSIONS = 8'd2;
   localparam logic [7:0] OP_PALETTE    = 8'd3;
   localparam logic [7:0] OP_SCALE      = 8'd4;
   localparam logic [7:0] OP_VSYNC      = 8'd5;

   localparam logic [7:0] CMODE_8BIT    = 8'd0;
   localparam logic [7:0] CMODE_16BIT   = 8'd1;
   localparam logic [7:0] CMODE_32BIT   = 8'd2;
   localparam logic [7:0] CMODE_15BIT   = 8'd4;

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_WAIT_FRAME = 2'd1,
      ST_ISSUE      = 2'd2,
      ST_GAP        = 2'd3
   } ctrl_state_t;

   function automatic logic op_is_legal(input logic [7:0] op);
      return (op != OP_NOP) && (op <= OP_VSYNC);
   endfunction

   // Deferred ops change frame geometry/format and must align to a frame boundary.
   function automatic logic op_is_deferred(input logic [7:0] op);
      logic d;
      d = 1'b0;
      case (op)
         OP_COLORMODE, OP_DIMENSIONS, OP_SCALE: d = 1'b1;
         default:                               d = 1'b0;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/ctrl_rr_arbiter.sv
// Two-way round-robin arbiter; grant is combinational, last winner is registered.
module ctrl_rr_arbiter (
   input  logic       m_axis_vid_aclk,
   input  logic       aresetn,
   input  logic       en,
   input  logic [1:0] req,
   output logic [1:0] grant
);

   // 0 = A won last, 1 = B won last; reset to B so A has first priority.
   logic last_b;

   always_ff @(posedge m_axis_vid_aclk) begin
      if (!aresetn) begin
         last_b <= 1'b1;
      end else if (grant != 2'b00) begin
         last_b <= grant[1];
      end
   end

   always_comb begin
      grant = '0;
      if (en) begin
         case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_b ? 2'b01 : 2'b10;
            default: grant = '0;
         endcase
      end
   end

endmodule

// File: rtl/video_ctrl_sequencer.sv
// Arbitrates host and palette-loader commands and issues them to the video
// pipeline, deferring format-changing commands to the next frame start.
module video_ctrl_sequencer #(
   parameter int unsigned HOLD_CYCLES   = 2,
   parameter int unsigned FRAME_TIMEOUT = 2000000
) (
   input  logic        m_axis_vid_aclk,
   input  logic        aresetn,
   input  logic        a_valid,
   output logic        a_ready,
   input  logic [7:0]  a_op,
   input  logic [31:0] a_data,
   input  logic        b_valid,
   output logic        b_ready,
   input  logic [7:0]  b_op,
   input  logic [31:0] b_data,
   input  logic        frame_start,
   output logic [7:0]  control_op,
   output logic [31:0] control_data,
   output logic        busy,
   output logic        err_bad_op,
   output logic        frame_timeout
);

   import video_ctrl_pkg::*;

   localparam logic [3:0]  HOLD_LAST = 4'(HOLD_CYCLES - 1);
   localparam logic [23:0] WAIT_LAST = 24'(FRAME_TIMEOUT - 1);

   ctrl_state_t state, state_nxt;

   logic [1:0]  grant;
   logic        transfer;
   logic        sel_legal;
   logic [7:0]  sel_op;
   logic [31:0] sel_data;
   logic [7:0]  op_q;
   logic [31:0] data_q;
   logic [3:0]  hold_cnt;
   logic [23:0] wait_cnt;
   logic        timeout_hit;
   logic        issue_entry;

   ctrl_rr_arbiter u_arb (
      .m_axis_vid_aclk (m_axis_vid_aclk),
      .aresetn         (aresetn),
      .en              ((state == ST_IDLE) && aresetn),
      .req             ({b_valid, a_valid}),
      .grant           (grant)
   );

   assign a_ready   = grant[0];
   assign b_ready   = grant[1];
   assign transfer  = |grant;
   assign sel_op    = grant[1] ? b_op   : a_op;
   assign sel_data  = grant[1] ? b_data : a_data;
   assign sel_legal = op_is_legal(sel_op);

   always_ff @(posedge m_axis_vid_aclk) begin
      if (!aresetn) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      timeout_hit = 1'b0;
      control_op  = OP_NOP;
      busy        = (state != ST_IDLE);
      case (state)
         ST_IDLE: begin
            if (transfer && sel_legal) begin
               if (op_is_deferred(sel_op) && !frame_start) begin
                  state_nxt = ST_WAIT_FRAME;
               end else begin
                  state_nxt = ST_ISSUE;
               end
            end
         end
         ST_WAIT_FRAME: begin
            if (frame_start) begin
               state_nxt = ST_ISSUE;
            end else if (wait_cnt == WAIT_LAST) begin
               state_nxt   = ST_ISSUE;
               timeout_hit = 1'b1;
            end
         end
         ST_ISSUE: begin
            control_op = op_q;
            if (hold_cnt == HOLD_LAST) begin
               state_nxt = ST_GAP;
            end
         end
         ST_GAP: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   assign issue_entry = (state_nxt == ST_ISSUE) && (state != ST_ISSUE);

   always_ff @(posedge m_axis_vid_aclk) begin
      if (!aresetn) begin
         op_q          <= '0;
         data_q        <= '0;
         control_data  <= '0;
         hold_cnt      <= '0;
         wait_cnt      <= '0;
         err_bad_op    <= 1'b0;
         frame_timeout <= 1'b0;
      end else begin
         if (transfer && sel_legal) begin
            op_q   <= sel_op;
            data_q <= sel_data;
         end
         if (transfer && !sel_legal) begin
            err_bad_op <= 1'b1;
         end
         if (timeout_hit) begin
            frame_timeout <= 1'b1;
         end
         hold_cnt <= (state == ST_ISSUE)      ? hold_cnt + 4'd1  : '0;
         wait_cnt <= (state == ST_WAIT_FRAME) ? wait_cnt + 24'd1 : '0;
         // Operand goes out together with the op: straight from the winning
         // requester on a direct issue, from the capture register after a wait.
         if (issue_entry) begin
            control_data <= (state == ST_IDLE) ? sel_data : data_q;
         end
      end
   end

endmodule

// File: tb/tb_video_ctrl_sequencer.sv
// Directed self-checking bench for video_ctrl_sequencer.
module tb_video_ctrl_sequencer;

   logic        clk;
   logic        aresetn;
   logic        a_valid, b_valid, frame_start;
   logic        a_ready, b_ready;
   logic [7:0]  a_op, b_op, control_op;
   logic [31:0] a_data, b_data, control_data;
   logic        busy, err_bad_op, frame_timeout;

   logic        t_a_valid, t_a_ready, t_b_ready;
   logic [7:0]  t_a_op, t_control_op;
   logic [31:0] t_a_data, t_control_data;
   logic        t_busy, t_err_bad_op, t_frame_timeout;

   int passed;
   int total;

   video_ctrl_sequencer #(.HOLD_CYCLES(2), .FRAME_TIMEOUT(2000000)) dut (
      .m_axis_vid_aclk (clk),
      .aresetn         (aresetn),
      .a_valid         (a_valid),
      .a_ready         (a_ready),
      .a_op            (a_op),
      .a_data          (a_data),
      .b_valid         (b_valid),
      .b_ready         (b_ready),
      .b_op            (b_op),
      .b_data          (b_data),
      .frame_start     (frame_start),
      .control_op      (control_op),
      .control_data    (control_data),
      .busy            (busy),
      .err_bad_op      (err_bad_op),
      .frame_timeout   (frame_timeout)
   );

   video_ctrl_sequencer #(.HOLD_CYCLES(2), .FRAME_TIMEOUT(50)) dut_to (
      .m_axis_vid_aclk (clk),
      .aresetn         (aresetn),
      .a_valid         (t_a_valid),
      .a_ready         (t_a_ready),
      .a_op            (t_a_op),
      .a_data          (t_a_data),
      .b_valid         (1'b0),
      .b_ready         (t_b_ready),
      .b_op            (8'd0),
      .b_data          (32'd0),
      .frame_start     (1'b0),
      .control_op      (t_control_op),
      .control_data    (t_control_data),
      .busy            (t_busy),
      .err_bad_op      (t_err_bad_op),
      .frame_timeout   (t_frame_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset;
      aresetn = 1'b0;
      a_valid = 1'b1; a_op = 8'd3;
      b_valid = 1'b1; b_op = 8'd3;
      repeat (3) @(negedge clk);
      total++; if (a_ready !== 1'b0) $display("FAIL rst_a_ready: got %b expected 0", a_ready); else passed++;
      total++; if (b_ready !== 1'b0) $display("FAIL rst_b_ready: got %b expected 0", b_ready); else passed++;
      total++; if (control_op !== 8'd0) $display("FAIL rst_op: got %h expected 00", control_op); else passed++;
      total++; if (control_data !== 32'd0) $display("FAIL rst_data: got %h expected 0", control_data); else passed++;
      total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b expected 0", busy); else passed++;
      total++; if (err_bad_op !== 1'b0 || frame_timeout !== 1'b0)
         $display("FAIL rst_flags: got %b%b expected 00", err_bad_op, frame_timeout); else passed++;
      total++; if (t_control_op !== 8'd0 || t_busy !== 1'b0)
         $display("FAIL rst_t_dut: got op %h busy %b expected 00/0", t_control_op, t_busy); else passed++;
      a_valid = 1'b0; b_valid = 1'b0;
      aresetn = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_immediate;
      a_valid = 1'b1; a_op = 8'd3; a_data = 32'h05FF0000;
      #1;
      total++; if (a_ready !== 1'b1) $display("FAIL imm_ready: got %b expected 1", a_ready); else passed++;
      @(negedge clk);
      total++; if (a_ready !== 1'b0) $display("FAIL imm_ready_busy: got %b expected 0", a_ready); else passed++;
      a_valid = 1'b0;
      total++; if (control_op !== 8'd3 || control_data !== 32'h05FF0000)
         $display("FAIL imm_t1: got %h/%h expected 03/05ff0000", control_op, control_data); else passed++;
      total++; if (busy !== 1'b1) $display("FAIL imm_busy: got %b expected 1", busy); else passed++;
      @(negedge clk);
      total++; if (control_op !== 8'd3) $display("FAIL imm_t2: got %h expected 03", control_op); else passed++;
      @(negedge clk);
      total++; if (control_op !== 8'd0 || control_data !== 32'h05FF0000 || busy !== 1'b1)
         $display("FAIL imm_gap: got %h/%h/%b expected 00/05ff0000/1", control_op, control_data, busy); else passed++;
      @(negedge clk);
      total++; if (busy !== 1'b0) $display("FAIL imm_idle: got %b expected 0", busy); else passed++;
   endtask

   task automatic test_deferred;
      int bad;
      bad = 0;
      a_valid = 1'b1; a_op = 8'd2; a_data = 32'h01000280;
      @(negedge clk);
      a_valid = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (control_op !== 8'd0 || busy !== 1'b1) bad++;
         @(negedge clk);
      end
      total++; if (bad != 0) $display("FAIL def_wait: got %0d bad cycles expected 0", bad); else passed++;
      frame_start = 1'b1;
      #1;
      total++; if (control_op !== 8'd0) $display("FAIL def_early: got %h expected 00", control_op); else passed++;
      @(negedge clk);
      frame_start = 1'b0;
      total++; if (control_op !== 8'd2 || control_data !== 32'h01000280)
         $display("FAIL def_issue: got %h/%h expected 02/01000280", control_op, control_data); else passed++;
      @(negedge clk);
      total++; if (control_op !== 8'd2) $display("FAIL def_issue2: got %h expected 02", control_op); else passed++;
      @(negedge clk);
      total++; if (control_op !== 8'd0) $display("FAIL def_gap: got %h expected 00", control_op); else passed++;
      @(negedge clk);
      total++; if (busy !== 1'b0 || frame_timeout !== 1'b0)
         $display("FAIL def_idle: got busy %b to %b expected 0/0", busy, frame_timeout); else passed++;
   endtask

   task automatic test_deferred_same_cycle;
      a_valid = 1'b1; a_op = 8'd1; a_data = 32'h00000002; frame_start = 1'b1;
      @(negedge clk);
      a_valid = 1'b0; frame_start = 1'b0;
      total++; if (control_op !== 8'd1 || control_data !== 32'h00000002)
         $display("FAIL same_cycle: got %h/%h expected 01/00000002", control_op, control_data); else passed++;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_frame_not_remembered;
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      a_valid = 1'b1; a_op = 8'd4; a_data = 32'h00000003;
      @(negedge clk);
      a_valid = 1'b0;
      total++; if (control_op !== 8'd0 || busy !== 1'b1)
         $display("FAIL stale_frame: got %h/%b expected 00/1", control_op, busy); else passed++;
      @(negedge clk);
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      total++; if (control_op !== 8'd4) $display("FAIL stale_release: got %h expected 04", control_op); else passed++;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_bad_op;
      b_valid = 1'b1; b_op = 8'd7; b_data = 32'hDEADBEEF;
      #1;
      total++; if (b_ready !== 1'b1) $display("FAIL bad_ready: got %b expected 1", b_ready); else passed++;
      @(negedge clk);
      b_valid = 1'b0;
      #1;
      total++; if (b_ready !== 1'b0) $display("FAIL bad_ready_low: got %b expected 0", b_ready); else passed++;
      total++; if (err_bad_op !== 1'b1) $display("FAIL bad_err: got %b expected 1", err_bad_op); else passed++;
      total++; if (control_op !== 8'd0 || busy !== 1'b0)
         $display("FAIL bad_quiet: got %h/%b expected 00/0", control_op, busy); else passed++;
      @(negedge clk);
      total++; if (err_bad_op !== 1'b1 || busy !== 1'b0)
         $display("FAIL bad_sticky: got %b/%b expected 1/0", err_bad_op, busy); else passed++;
   endtask

   task automatic test_round_robin;
      logic [3:0]  seq;
      int          at [4];
      int          n;
      int          both;
      logic [31:0] d1, d5;
      n = 0; both = 0; seq = '0; d1 = '0; d5 = '0;
      a_valid = 1'b1; a_op = 8'd3; a_data = 32'hAAAA0001;
      b_valid = 1'b1; b_op = 8'd3; b_data = 32'hBBBB0001;
      for (int cyc = 0; cyc < 16; cyc++) begin
         #1;
         if (a_ready && b_ready) both++;
         if ((a_ready || b_ready) && n < 4) begin
            seq[n] = b_ready;
            at[n]  = cyc;
            n++;
         end
         if (cyc == 1) d1 = control_data;
         if (cyc == 5) d5 = control_data;
         @(negedge clk);
      end
      a_valid = 1'b0; b_valid = 1'b0;
      total++; if (n != 4) $display("FAIL rr_count: got %0d expected 4", n); else passed++;
      total++; if (seq !== 4'b1010) $display("FAIL rr_order: got %b expected 1010 (B,A,B,A msb first)", seq); else passed++;
      total++; if (n == 4 && (at[0] != 0 || at[1] != 4 || at[2] != 8 || at[3] != 12))
         $display("FAIL rr_spacing: got %0d,%0d,%0d,%0d expected 0,4,8,12", at[0], at[1], at[2], at[3]); else passed++;
      total++; if (both != 0) $display("FAIL rr_exclusive: got %0d expected 0", both); else passed++;
      total++; if (d1 !== 32'hAAAA0001 || d5 !== 32'hBBBB0001)
         $display("FAIL rr_data: got %h,%h expected aaaa0001,bbbb0001", d1, d5); else passed++;
   endtask

   task automatic test_timeout;
      int bad;
      bad = 0;
      t_a_valid = 1'b1; t_a_op = 8'd4; t_a_data = 32'h00010002;
      @(negedge clk);
      t_a_valid = 1'b0;
      for (int i = 0; i < 49; i++) begin
         if (t_control_op !== 8'd0 || t_frame_timeout !== 1'b0) bad++;
         @(negedge clk);
      end
      total++; if (bad != 0) $display("FAIL to_wait: got %0d bad cycles expected 0", bad); else passed++;
      total++; if (t_control_op !== 8'd0 || t_frame_timeout !== 1'b0)
         $display("FAIL to_last_wait: got %h/%b expected 00/0", t_control_op, t_frame_timeout); else passed++;
      @(negedge clk);
      total++; if (t_control_op !== 8'd4 || t_control_data !== 32'h00010002)
         $display("FAIL to_issue: got %h/%h expected 04/00010002", t_control_op, t_control_data); else passed++;
      total++; if (t_frame_timeout !== 1'b1) $display("FAIL to_flag: got %b expected 1", t_frame_timeout); else passed++;
      repeat (3) @(negedge clk);
      total++; if (t_frame_timeout !== 1'b1 || t_busy !== 1'b0)
         $display("FAIL to_sticky: got %b/%b expected 1/0", t_frame_timeout, t_busy); else passed++;
   endtask

   task automatic test_reset_mid_issue;
      a_valid = 1'b1; a_op = 8'd1; a_data = 32'h00000004; frame_start = 1'b1;
      @(negedge clk);
      a_valid = 1'b0; frame_start = 1'b0;
      total++; if (control_op !== 8'd1) $display("FAIL mid_issue: got %h expected 01", control_op); else passed++;
      aresetn = 1'b0;
      @(negedge clk);
      total++; if (control_op !== 8'd0 || control_data !== 32'd0 || busy !== 1'b0)
         $display("FAIL mid_rst_out: got %h/%h/%b expected 00/0/0", control_op, control_data, busy); else passed++;
      total++; if (err_bad_op !== 1'b0 || t_frame_timeout !== 1'b0)
         $display("FAIL mid_rst_flags: got %b/%b expected 0/0", err_bad_op, t_frame_timeout); else passed++;
      aresetn = 1'b1;
      a_valid = 1'b1; a_op = 8'd3; a_data = 32'h12345678;
      #1;
      total++; if (a_ready !== 1'b1) $display("FAIL post_rst_ready: got %b expected 1", a_ready); else passed++;
      @(negedge clk);
      a_valid = 1'b0;
      total++; if (control_op !== 8'd3 || control_data !== 32'h12345678)
         $display("FAIL post_rst_issue: got %h/%h expected 03/12345678", control_op, control_data); else passed++;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      passed = 0; total = 0;
      aresetn = 1'b0;
      a_valid = 1'b0; a_op = '0; a_data = '0;
      b_valid = 1'b0; b_op = '0; b_data = '0;
      frame_start = 1'b0;
      t_a_valid = 1'b0; t_a_op = '0; t_a_data = '0;
      test_reset;
      test_immediate;
      test_deferred;
      test_deferred_same_cycle;
      test_frame_not_remembered;
      test_bad_op;
      test_round_robin;
      test_timeout;
      test_reset_mid_issue;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
